moore_seqdet: RTL and testbench



---
 rtl/moore_seqdet.sv | 60 ++++++
 tb/tb_moore_seqdet.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/moore_seqdet.sv
// Moore detector for the serial pattern 1-0-1-0 (first bit first).
// The flag y is decoded from the registered state only, so it is never combinational on t.
module moore_seqdet #(
    parameter logic OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic y
);

    // Each state is named by the useful prefix of the pattern it has seen.
    typedef enum logic [2:0] {
        S0 = 3'b000,  // idle, no useful prefix
        S1 = 3'b001,  // "1"
        S2 = 3'b010,  // "10"
        S3 = 3'b011,  // "101"
        S4 = 3'b100   // "1010" matched
    } state_e;

    // Kept as a plain vector so the unused codes 101/110/111 stay representable.
    logic [2:0] state_q;
    logic [2:0] state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        // A t that is neither 0 nor 1 falls to the default and returns to idle.
        case (t)
            1'b1: begin
                case (state_q)
                    S0:      state_d = S1;
                    S1:      state_d = S1;
                    S2:      state_d = S3;
                    S3:      state_d = S1;
                    S4:      state_d = OVERLAP ? S3 : S1;
                    default: state_d = S0;
                endcase
            end
            1'b0: begin
                case (state_q)
                    S1:      state_d = S2;
                    S3:      state_d = S4;
                    default: state_d = S0;
                endcase
            end
            default: state_d = S0;
        endcase
    end

    assign y = (state_q == S4);

endmodule

// File: tb/tb_moore_seqdet.sv
// Bench for moore_seqdet: an overlapping and a non-overlapping instance share one input stream.
// Expected flags and states are pushed when a bit is driven and popped after the sampling edge.
module tb_moore_seqdet;

    localparam int W = 2;
    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [2:0] S4 = 3'b100;

    logic clk = 1'b0;
    logic rst_n;
    logic t;
    logic y_ov;
    logic y_no;

    logic [W-1:0] exp_q[$];
    logic [5:0]   st_q[$];
    int errors = 0;
    int checks = 0;

    moore_seqdet #(.OVERLAP(1'b1)) dut_ov (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .y     (y_ov)
    );

    moore_seqdet #(.OVERLAP(1'b0)) dut_no (
        .clk   (clk),
        .rst_n (rst_n),
        .t     (t),
        .y     (y_no)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit before the edge, then compare both flags just after it.
    task automatic send(input logic b, input logic ey_ov, input logic ey_no, input string tag);
        logic [W-1:0] e;
        @(negedge clk);
        t = b;
        exp_q.push_back({ey_ov, ey_no});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, " y"}, {6'd0, y_ov, y_no}, {6'd0, e});
    endtask

    task automatic send_st(input logic b, input logic ey_ov, input logic ey_no,
                           input logic [2:0] es_ov, input logic [2:0] es_no, input string tag);
        logic [5:0] e;
        st_q.push_back({es_ov, es_no});
        send(b, ey_ov, ey_no, tag);
        e = st_q.pop_front();
        check({tag, " state"}, {2'd0, dut_ov.state_q, dut_no.state_q}, {2'd0, e});
    endtask

    // Asserts reset mid-cycle and checks the effect before any clock edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, " y"}, {6'd0, y_ov, y_no}, 8'd0);
        check({tag, " state"}, {2'd0, dut_ov.state_q, dut_no.state_q}, 8'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        t     = 1'b0;
        @(posedge clk);
        #1;
        check("reset_y", {6'd0, y_ov, y_no}, 8'd0);
        check("reset_state", {2'd0, dut_ov.state_q, dut_no.state_q}, 8'd0);
        release_reset();

        // Basic match 0,1,0,1,0 then a trailing 0
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "basic0");
        send_st(1'b1, 1'b0, 1'b0, S1, S1, "basic1");
        send_st(1'b0, 1'b0, 1'b0, S2, S2, "basic2");
        send_st(1'b1, 1'b0, 1'b0, S3, S3, "basic3");
        send_st(1'b0, 1'b1, 1'b1, S4, S4, "basic4");
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "basic5");

        // Overlap vs non-overlap on 0,1,1,0,1,0,1,0,1,0,1,0
        send(1'b0, 1'b0, 1'b0, "ovl01");
        send(1'b1, 1'b0, 1'b0, "ovl02");
        send(1'b1, 1'b0, 1'b0, "ovl03");
        send(1'b0, 1'b0, 1'b0, "ovl04");
        send(1'b1, 1'b0, 1'b0, "ovl05");
        send(1'b0, 1'b1, 1'b1, "ovl06");
        send(1'b1, 1'b0, 1'b0, "ovl07");
        send(1'b0, 1'b1, 1'b0, "ovl08");
        send(1'b1, 1'b0, 1'b0, "ovl09");
        send(1'b0, 1'b1, 1'b1, "ovl10");
        send(1'b1, 1'b0, 1'b0, "ovl11");
        send_st(1'b0, 1'b1, 1'b0, S4, S2, "ovl12");
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "flush1");
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "flush2");

        // Near misses 1,1,0,0,1,0,1,1
        send_st(1'b1, 1'b0, 1'b0, S1, S1, "near1");
        send_st(1'b1, 1'b0, 1'b0, S1, S1, "near2");
        send_st(1'b0, 1'b0, 1'b0, S2, S2, "near3");
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "near4");
        send_st(1'b1, 1'b0, 1'b0, S1, S1, "near5");
        send_st(1'b0, 1'b0, 1'b0, S2, S2, "near6");
        send_st(1'b1, 1'b0, 1'b0, S3, S3, "near7");
        send_st(1'b1, 1'b0, 1'b0, S1, S1, "near8");

        // Reach S3, then reset mid-cycle and hold it across an edge with t=1
        send_st(1'b0, 1'b0, 1'b0, S2, S2, "pre_rst1");
        send_st(1'b1, 1'b0, 1'b0, S3, S3, "pre_rst2");
        async_reset("rst_s3");
        @(negedge clk);
        t = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_state", {2'd0, dut_ov.state_q, dut_no.state_q}, 8'd0);
        check("rst_hold_y", {6'd0, y_ov, y_no}, 8'd0);
        release_reset();

        send_st(1'b1, 1'b0, 1'b0, S1, S1, "post_rst1");
        send_st(1'b0, 1'b0, 1'b0, S2, S2, "post_rst2");
        send_st(1'b1, 1'b0, 1'b0, S3, S3, "post_rst3");
        send_st(1'b0, 1'b1, 1'b1, S4, S4, "post_rst4");

        // Reset while the flag is high drops it at once
        async_reset("rst_s4");
        release_reset();
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "post_rst5");

        // Illegal code 111 must return to S0 even with t=1
        force dut_ov.state_q = 3'b111;
        force dut_no.state_q = 3'b111;
        #1;
        check("illegal_y", {6'd0, y_ov, y_no}, 8'd0);
        release dut_ov.state_q;
        release dut_no.state_q;
        send_st(1'b1, 1'b0, 1'b0, S0, S0, "illegal_next");
        send_st(1'b0, 1'b0, 1'b0, S0, S0, "illegal_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
